// File: rtl/tcb_lib_misaligned_splitter.sv
// rtl/tcb_lib_misaligned_splitter.sv - unaligned TCB manager to aligned byte-enable TCB subordinate bridge
module tcb_lib_misaligned_splitter #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned DLY = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             man_vld,
  output logic             man_rdy,
  input  logic             man_wen,
  input  logic [ABW-1:0]   man_adr,
  input  logic [1:0]       man_siz,
  input  logic [DBW-1:0]   man_wdt,
  output logic [DBW-1:0]   man_rdt,
  output logic             man_err,
  output logic             man_rvl,
  output logic             sub_vld,
  input  logic             sub_rdy,
  output logic             sub_wen,
  output logic [ABW-1:0]   sub_adr,
  output logic [DBW/8-1:0] sub_byt,
  output logic [DBW-1:0]   sub_wdt,
  input  logic [DBW-1:0]   sub_rdt,
  input  logic             sub_err
);

  if (DBW != 32) begin : g_dbw_chk
    $error("tcb_lib_misaligned_splitter: DBW must be 32");
  end
  if ((DLY < 1) || (DLY > 4)) begin : g_dly_chk
    $error("tcb_lib_misaligned_splitter: DLY must be in 1..4");
  end

  typedef struct packed {
    logic       v;
    logic       last;
    logic       split;
    logic [1:0] off;
    logic [1:0] siz;
    logic [3:0] byt;
  } tag_t;

  logic [1:0]     off;
  logic [3:0]     msk;
  logic [7:0]     full;
  logic           split;
  logic           last;
  logic           sub_hs;
  logic           phase;
  logic           phase_nxt;
  logic [ABW-1:0] adr_aln;
  logic [63:0]    wdt_dup;
  tag_t           tag_in;
  tag_t           tags [DLY];
  tag_t           tag_out;
  logic [31:0]    hold_rdt;
  logic           hold_err;
  logic [31:0]    merged;
  logic [63:0]    rdt_dup;
  logic [31:0]    rdt_msk;

  assign off     = man_adr[1:0];
  assign full    = {4'b0000, msk} << off;
  assign split   = |full[7:4];
  assign last    = phase | ~split;
  assign sub_hs  = man_vld & sub_rdy;
  assign adr_aln = {man_adr[ABW-1:2], 2'b00};
  assign wdt_dup = {man_wdt, man_wdt} << {off, 3'b000};
  assign tag_out = tags[DLY-1];

  // byte mask of the transfer size, before lane placement
  always_comb begin
    case (man_siz)
      2'd0:    msk = 4'b0001;
      2'd1:    msk = 4'b0011;
      default: msk = 4'b1111;
    endcase
  end

  // phase register: 0 = single or first part, 1 = second part of a split
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= 1'b0;
    else     phase <= phase_nxt;
  end

  // next phase: a handshake on the first part of a split moves to the second part
  always_comb begin
    phase_nxt = phase;
    if (sub_hs) begin
      if (phase)      phase_nxt = 1'b0;
      else if (split) phase_nxt = 1'b1;
    end
  end

  // request outputs; manager is only acknowledged on the last part
  always_comb begin
    sub_vld = man_vld;
    sub_wen = man_wen;
    sub_wdt = wdt_dup[63:32];
    if (phase) begin
      sub_adr = adr_aln + ABW'(4);
      sub_byt = full[7:4];
      man_rdy = sub_rdy;
    end else begin
      sub_adr = adr_aln;
      sub_byt = full[3:0];
      man_rdy = sub_rdy & ~split;
    end
  end

  // tag describing the current subordinate transfer
  always_comb begin
    tag_in       = '0;
    tag_in.v     = sub_hs;
    tag_in.last  = last;
    tag_in.split = split;
    tag_in.off   = off;
    tag_in.siz   = man_siz;
    tag_in.byt   = full[3:0];
  end

  // tag pipeline aligned with the subordinate response delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= tag_in;
      for (int i = 1; i < DLY; i++) tags[i] <= tags[i-1];
    end
  end

  // park the first-part response until the second part returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_rdt <= '0;
      hold_err <= 1'b0;
    end else if (tag_out.v && !tag_out.last) begin
      hold_rdt <= sub_rdt;
      hold_err <= sub_err;
    end
  end

  // merge both parts, right-align to the byte offset and mask to size
  always_comb begin
    merged = sub_rdt;
    if (tag_out.split) begin
      for (int i = 0; i < 4; i++) begin
        if (tag_out.byt[i]) merged[8*i +: 8] = hold_rdt[8*i +: 8];
      end
    end
    rdt_dup = {merged, merged} >> {tag_out.off, 3'b000};
    case (tag_out.siz)
      2'd0:    rdt_msk = 32'h0000_00FF;
      2'd1:    rdt_msk = 32'h0000_FFFF;
      default: rdt_msk = 32'hFFFF_FFFF;
    endcase
    man_rvl = tag_out.v & tag_out.last;
    man_rdt = man_rvl ? (rdt_dup[31:0] & rdt_msk) : '0;
    man_err = man_rvl & (sub_err | (tag_out.split & hold_err));
  end

  // size code 3 has no meaning on a 32-bit bus
  always @(posedge clk) begin
    if (!rst && man_vld) assert (man_siz != 2'd3);
  end

endmodule

// File: tb/tb_tcb_lib_misaligned_splitter.sv
// tb/tb_tcb_lib_misaligned_splitter.sv - self-checking bench for the misaligned splitter (DLY 1 and 3)
module tb_tcb_lib_misaligned_splitter;

  typedef struct {
    int          due;
    logic        wen;
    logic [31:0] dat;
    logic [1:0]  siz;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        man_vld, man_wen;
  logic [31:0] man_adr, man_wdt;
  logic [1:0]  man_siz;
  logic        sub_rdy, err_next;

  logic        m1_rdy, m1_err, m1_rvl, s1_vld, s1_wen;
  logic [31:0] m1_rdt, s1_adr, s1_wdt;
  logic [3:0]  s1_byt;
  logic        m3_rdy, m3_err, m3_rvl, s3_vld, s3_wen;
  logic [31:0] m3_rdt, s3_adr, s3_wdt;
  logic [3:0]  s3_byt;

  logic [31:0] p_dat [3];
  logic        p_err [3];
  logic [31:0] sub_rdt1, sub_rdt3;
  logic        sub_err1, sub_err3;
  assign sub_rdt1 = p_dat[0];
  assign sub_err1 = p_err[0];
  assign sub_rdt3 = p_dat[2];
  assign sub_err3 = p_err[2];

  logic [7:0] sub_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  exp_t q1[$];
  exp_t q3[$];
  int   cyc = 0;
  int   hs_cnt = 0;
  logic err_acc = 1'b0;
  int   errors = 0;
  int   checks = 0;

  tcb_lib_misaligned_splitter #(.ABW(32), .DBW(32), .DLY(1)) u1 (
    .clk(clk), .rst(rst),
    .man_vld(man_vld), .man_rdy(m1_rdy), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_wdt(man_wdt), .man_rdt(m1_rdt), .man_err(m1_err), .man_rvl(m1_rvl),
    .sub_vld(s1_vld), .sub_rdy(sub_rdy), .sub_wen(s1_wen), .sub_adr(s1_adr),
    .sub_byt(s1_byt), .sub_wdt(s1_wdt), .sub_rdt(sub_rdt1), .sub_err(sub_err1)
  );

  tcb_lib_misaligned_splitter #(.ABW(32), .DBW(32), .DLY(3)) u3 (
    .clk(clk), .rst(rst),
    .man_vld(man_vld), .man_rdy(m3_rdy), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_wdt(man_wdt), .man_rdt(m3_rdt), .man_err(m3_err), .man_rvl(m3_rvl),
    .sub_vld(s3_vld), .sub_rdy(sub_rdy), .sub_wen(s3_wen), .sub_adr(s3_adr),
    .sub_byt(s3_byt), .sub_wdt(s3_wdt), .sub_rdt(sub_rdt3), .sub_err(sub_err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sub_byte(input logic [31:0] a);
    if (sub_mem.exists(a)) return sub_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] siz_msk(input logic [1:0] s);
    case (s)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      sub_mem[a + 32'(i)] = w[8*i +: 8];
      ref_mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [31:0] adr, input logic [1:0] siz, input logic [31:0] wdt);
    man_vld = 1'b1;
    man_wen = wen;
    man_adr = adr;
    man_siz = siz;
    man_wdt = wdt;
  endtask

  // one full manager request with random subordinate back-pressure
  task automatic req(input logic wen, input logic [31:0] adr, input logic [1:0] siz, input logic [31:0] wdt, input int pct);
    logic got;
    got = 1'b0;
    drive(wen, adr, siz, wdt);
    for (int k = 0; k < 200 && !got; k++) begin
      sub_rdy  = ($urandom_range(99) < pct);
      err_next = (pct < 100) && ($urandom_range(7) == 0);
      @(negedge clk);
      got = m1_rdy;
      tick();
    end
    check("req_timeout", 32'(got), 32'd1);
    man_vld  = 1'b0;
    sub_rdy  = 1'b0;
    err_next = 1'b0;
  endtask

  // subordinate memory model plus request-level reference scoreboard
  always @(posedge clk) begin : sub_model
    logic [31:0] rd, ex;
    logic        e;
    exp_t        t;
    int          n;
    cyc = cyc + 1;
    rd  = 32'hDEAD_BEEF;
    e   = 1'b0;
    if (rst) begin
      q1.delete();
      q3.delete();
      err_acc = 1'b0;
    end else if (s1_vld && sub_rdy) begin
      hs_cnt++;
      e = err_next;
      for (int i = 0; i < 4; i++) rd[8*i +: 8] = sub_byte(s1_adr + 32'(i));
      if (man_vld && m1_rdy) begin
        n  = 1 << man_siz;
        ex = '0;
        for (int i = 0; i < n; i++) ex[8*i +: 8] = ref_byte(man_adr + 32'(i));
        if (man_wen) for (int i = 0; i < n; i++) ref_mem[man_adr + 32'(i)] = man_wdt[8*i +: 8];
        t.wen = man_wen;
        t.dat = ex;
        t.siz = man_siz;
        t.err = err_acc | e;
        t.due = cyc;
        q1.push_back(t);
        t.due = cyc + 2;
        q3.push_back(t);
        err_acc = 1'b0;
      end else begin
        err_acc = err_acc | e;
      end
      if (s1_wen) begin
        for (int i = 0; i < 4; i++) if (s1_byt[i]) sub_mem[s1_adr + 32'(i)] = s1_wdt[8*i +: 8];
      end
    end
    p_dat[0] <= rd;
    p_dat[1] <= p_dat[0];
    p_dat[2] <= p_dat[1];
    p_err[0] <= e;
    p_err[1] <= p_err[0];
    p_err[2] <= p_err[1];
  end

  // response monitor for both delays
  always @(negedge clk) begin : resp_mon
    exp_t h;
    logic d;
    if (rst) begin
      check("rst_rvl1", 32'(m1_rvl), 32'd0);
      check("rst_rvl3", 32'(m3_rvl), 32'd0);
    end else begin
      d = (q1.size() != 0) && (q1[0].due == cyc);
      check("rvl1", 32'(m1_rvl), 32'(d));
      if (d) begin
        h = q1.pop_front();
        if (!h.wen) check("rdt1", m1_rdt, h.dat);
        check("err1", 32'(m1_err), 32'(h.err));
        check("msk1", m1_rdt & ~siz_msk(h.siz), 32'd0);
      end else begin
        check("idle_rdt1", m1_rdt, 32'd0);
        check("idle_err1", 32'(m1_err), 32'd0);
      end
      d = (q3.size() != 0) && (q3[0].due == cyc);
      check("rvl3", 32'(m3_rvl), 32'(d));
      if (d) begin
        h = q3.pop_front();
        if (!h.wen) check("rdt3", m3_rdt, h.dat);
        check("err3", 32'(m3_err), 32'(h.err));
        check("msk3", m3_rdt & ~siz_msk(h.siz), 32'd0);
      end else begin
        check("idle_rdt3", m3_rdt, 32'd0);
        check("idle_err3", 32'(m3_err), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    rst = 1'b1; man_vld = 1'b0; man_wen = 1'b0; man_adr = '0; man_siz = '0; man_wdt = '0;
    sub_rdy = 1'b0; err_next = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_rvl", 32'(m1_rvl), 32'd0);
    check("reset_rdt", m1_rdt, 32'd0);
    check("reset_err", 32'(m1_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // aligned word read
    preload(32'h100, 32'hDDCC_BBAA);
    drive(1'b0, 32'h100, 2'd2, 32'h0);
    sub_rdy = 1'b1;
    @(negedge clk);
    check("al_adr", s1_adr, 32'h100);
    check("al_byt", 32'(s1_byt), 32'hF);
    check("al_rdy", 32'(m1_rdy), 32'd1);
    tick();
    man_vld = 1'b0;
    @(negedge clk);
    check("al_rvl", 32'(m1_rvl), 32'd1);
    check("al_rdt", m1_rdt, 32'hDDCC_BBAA);
    repeat (3) tick();

    // byte write at offset 3
    drive(1'b1, 32'h203, 2'd0, 32'h0000_00A5);
    sub_rdy = 1'b1;
    @(negedge clk);
    check("bw_adr", s1_adr, 32'h200);
    check("bw_byt", 32'(s1_byt), 32'h8);
    check("bw_wdt", s1_wdt, 32'hA500_0000);
    check("bw_rdy", 32'(m1_rdy), 32'd1);
    check("bw_wen", 32'(s1_wen), 32'd1);
    tick();
    man_vld = 1'b0;
    repeat (3) tick();

    // split word read across a word boundary
    preload(32'h100, 32'h2222_1111);
    preload(32'h104, 32'h4444_3333);
    drive(1'b0, 32'h102, 2'd2, 32'h0);
    sub_rdy = 1'b1;
    @(negedge clk);
    check("sr_adr0", s1_adr, 32'h100);
    check("sr_byt0", 32'(s1_byt), 32'hC);
    check("sr_rdy0", 32'(m1_rdy), 32'd0);
    tick();
    @(negedge clk);
    check("sr_adr1", s1_adr, 32'h104);
    check("sr_byt1", 32'(s1_byt), 32'h3);
    check("sr_rdy1", 32'(m1_rdy), 32'd1);
    check("sr_norvl", 32'(m1_rvl), 32'd0);
    tick();
    man_vld = 1'b0;
    @(negedge clk);
    check("sr_rvl", 32'(m1_rvl), 32'd1);
    check("sr_rdt", m1_rdt, 32'h3333_2222);
    tick();
    @(negedge clk);
    check("sr_once", 32'(m1_rvl), 32'd0);
    repeat (3) tick();

    // split half write with stall between parts and first-part error
    h0 = hs_cnt;
    drive(1'b1, 32'h07, 2'd1, 32'h0000_BEEF);
    sub_rdy  = 1'b1;
    err_next = 1'b1;
    @(negedge clk);
    check("sw_adr0", s1_adr, 32'h4);
    check("sw_byt0", 32'(s1_byt), 32'h8);
    check("sw_wdt0", s1_wdt, 32'hEF00_00BE);
    tick();
    err_next = 1'b0;
    sub_rdy  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("sw_stall_rdy", 32'(m1_rdy), 32'd0);
      check("sw_adr1", s1_adr, 32'h8);
      check("sw_byt1", 32'(s1_byt), 32'h1);
      check("sw_wdt1", s1_wdt, 32'hEF00_00BE);
      tick();
    end
    sub_rdy = 1'b1;
    @(negedge clk);
    check("sw_rdy1", 32'(m1_rdy), 32'd1);
    tick();
    man_vld = 1'b0;
    sub_rdy = 1'b0;
    @(negedge clk);
    check("sw_rvl", 32'(m1_rvl), 32'd1);
    check("sw_err", 32'(m1_err), 32'd1);
    check("sw_hs_cnt", 32'(hs_cnt - h0), 32'd2);
    repeat (4) tick();

    // random back-to-back mixed stream
    for (int n = 0; n < 200; n++) begin
      req(1'(($urandom_range(1))), 32'($urandom_range(63)), 2'($urandom_range(2)), $urandom(), 70);
      if ($urandom_range(3) == 0) tick();
    end
    sub_rdy = 1'b1;
    repeat (6) tick();
    sub_rdy = 1'b0;

    // reset during the second part of a split read
    drive(1'b0, 32'h0E, 2'd2, 32'h0);
    sub_rdy = 1'b1;
    tick();
    sub_rdy = 1'b0;
    @(negedge clk);
    check("rs_byt1", 32'(s1_byt), 32'h3);
    check("rs_adr1", s1_adr, 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check("rs_vld", 32'(s1_vld), 32'd1);
    check("rs_byt0", 32'(s1_byt), 32'hC);
    check("rs_adr0", s1_adr, 32'hC);
    check("rs_rvl", 32'(m1_rvl), 32'd0);
    tick();
    man_vld = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    preload(32'h100, 32'h1234_5678);
    req(1'b0, 32'h100, 2'd2, 32'h0, 100);
    @(negedge clk);
    check("post_rvl", 32'(m1_rvl), 32'd1);
    check("post_rdt", m1_rdt, 32'h1234_5678);
    repeat (5) tick();

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
